// File: rtl/dp_mem_pkg.sv
// Shared definitions for the dual-port memory initialisation engine.
// Pattern codes match the encoding used by the companion dual-port ROM.
package dp_mem_pkg;

  // Engine phases; VREAD/VDRAIN are only reached when VERIFY_EN is defined.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WRITE  = 3'd1,
    S_VREAD  = 3'd2,
    S_VDRAIN = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  // Pattern codes (code 3 behaves as zeros).
  localparam logic [1:0] PAT_ZERO   = 2'd0;
  localparam logic [1:0] PAT_QUAD   = 2'd1;
  localparam logic [1:0] PAT_LINEAR = 2'd2;

endpackage

// File: rtl/dual_port_mem_writer_pattern_gen.sv
// dp_pattern_gen: incremental generator for the (even, odd) word pair of
// pair index k, i.e. addresses 2k and 2k+1. Quad values f(a) = a*a + a are
// produced with adders only. When load is high the outputs show pair 0
// immediately; load or step advances the stored state to the following pair.
module dp_pattern_gen
  import dp_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  step,
  input  logic [1:0]            sel,
  output logic [DATA_WIDTH-1:0] even_val,
  output logic [DATA_WIDTH-1:0] odd_val
);

  // base_q tracks the even address 2k (mod 2^DATA_WIDTH), fe_q tracks f(2k).
  logic [DATA_WIDTH-1:0] base_q, fe_q;
  logic [DATA_WIDTH-1:0] cur_base, cur_fe;

  // Select the pair being presented this cycle and derive both words from it.
  always_comb begin
    cur_base = load ? '0 : base_q;
    cur_fe   = load ? '0 : fe_q;
    even_val = '0;
    odd_val  = '0;
    case (sel)
      PAT_QUAD: begin
        even_val = cur_fe;
        odd_val  = cur_fe + (cur_base << 1) + DATA_WIDTH'(2);
      end
      PAT_LINEAR: begin
        even_val = cur_base;
        odd_val  = cur_base | DATA_WIDTH'(1);
      end
      default: ;
    endcase
  end

  // Advance to the next pair: f(2k+2) = f(2k) + 4(2k) + 6.
  always_ff @(posedge clk) begin
    if (reset) begin
      base_q <= '0;
      fe_q   <= '0;
    end else if (load || step) begin
      base_q <= cur_base + DATA_WIDTH'(2);
      fe_q   <= cur_fe + (cur_base << 2) + DATA_WIDTH'(6);
    end
  end

endmodule

// File: rtl/dual_port_mem_writer.sv
// dual_port_mem_writer: loads a pattern into a dual-port RAM two words per
// cycle (port A even addresses, port B odd addresses). Optional feature
// macro VERIFY_EN adds a read-back pass that flags the first mismatch.
//
// Control contract: start is a level sampled only in S_IDLE; the edge that
// sees it is the accept edge. busy is high from the next cycle until the
// cycle before done; done is a single-cycle pulse; start seen while busy or
// during done is dropped. All outputs are registered and reset to 0.
module dual_port_mem_writer
  import dp_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int MEM_DEPTH  = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            pattern_sel,
  output logic                  busy,
  output logic                  done,
  output logic                  we_a,
  output logic                  we_b,
  output logic [ADDR_WIDTH-1:0] addr_a,
  output logic [ADDR_WIDTH-1:0] addr_b,
  output logic [DATA_WIDTH-1:0] wdata_a,
  output logic [DATA_WIDTH-1:0] wdata_b,
  output logic                  re_a,
  output logic                  re_b,
  input  logic [DATA_WIDTH-1:0] rdata_a,
  input  logic [DATA_WIDTH-1:0] rdata_b,
  output logic                  error,
  output logic [ADDR_WIDTH-1:0] err_addr,
  output state_t                state_dbg
);

  localparam logic [ADDR_WIDTH-1:0] LAST_PAIR = ADDR_WIDTH'((MEM_DEPTH + 1) / 2 - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH + 1)'(MEM_DEPTH);

  state_t                state_q, state_n;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_n;
  logic [1:0]            pat_q, gen_sel;
  logic                  gen_load, gen_step, issue_wr, busy_n, done_n, b_valid;
  logic [ADDR_WIDTH-1:0] addr_n;
  logic [DATA_WIDTH-1:0] even_val, odd_val;
`ifdef VERIFY_EN
  logic                  issue_rd;
`endif

  assign state_dbg = state_q;
  // The pattern code is taken live on the accept edge, latched afterwards.
  assign gen_sel   = (state_q == S_IDLE) ? pattern_sel : pat_q;
  assign addr_n    = {cnt_n[ADDR_WIDTH-2:0], 1'b0};
  // Port B is idle on the final pair when the depth is odd.
  assign b_valid   = ({cnt_n, 1'b1} < DEPTH_W);

  dp_pattern_gen #(.DATA_WIDTH(DATA_WIDTH)) u_gen (
    .clk      (clk),
    .reset    (reset),
    .load     (gen_load),
    .step     (gen_step),
    .sel      (gen_sel),
    .even_val (even_val),
    .odd_val  (odd_val)
  );

  // Next-state logic; decides which pair (if any) is presented next cycle.
  always_comb begin
    state_n  = state_q;
    cnt_n    = cnt_q;
    gen_load = 1'b0;
    gen_step = 1'b0;
    issue_wr = 1'b0;
    busy_n   = 1'b0;
    done_n   = 1'b0;
`ifdef VERIFY_EN
    issue_rd = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_n  = S_WRITE;
          cnt_n    = '0;
          gen_load = 1'b1;
          issue_wr = 1'b1;
          busy_n   = 1'b1;
        end
      end
      S_WRITE: begin
        if (cnt_q == LAST_PAIR) begin
`ifdef VERIFY_EN
          state_n  = S_VREAD;
          cnt_n    = '0;
          gen_load = 1'b1;
          issue_rd = 1'b1;
          busy_n   = 1'b1;
`else
          state_n  = S_DONE;
          done_n   = 1'b1;
`endif
        end else begin
          cnt_n    = cnt_q + ADDR_WIDTH'(1);
          gen_step = 1'b1;
          issue_wr = 1'b1;
          busy_n   = 1'b1;
        end
      end
`ifdef VERIFY_EN
      S_VREAD: begin
        busy_n = 1'b1;
        if (cnt_q == LAST_PAIR) begin
          state_n = S_VDRAIN;
        end else begin
          cnt_n    = cnt_q + ADDR_WIDTH'(1);
          gen_step = 1'b1;
          issue_rd = 1'b1;
        end
      end
      S_VDRAIN: begin
        state_n = S_DONE;
        done_n  = 1'b1;
      end
`endif
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // State, pair counter and the registered write-side outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pat_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      we_a    <= 1'b0;
      we_b    <= 1'b0;
      addr_a  <= '0;
      addr_b  <= '0;
      wdata_a <= '0;
      wdata_b <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      busy    <= busy_n;
      done    <= done_n;
      if (state_q == S_IDLE && start) pat_q <= pattern_sel;
      we_a    <= issue_wr;
      we_b    <= issue_wr && b_valid;
      wdata_a <= issue_wr ? even_val : '0;
      wdata_b <= (issue_wr && b_valid) ? odd_val : '0;
`ifdef VERIFY_EN
      addr_a  <= (issue_wr || issue_rd) ? addr_n : '0;
      addr_b  <= (issue_wr || issue_rd) ? (addr_n | ADDR_WIDTH'(1)) : '0;
`else
      addr_a  <= issue_wr ? addr_n : '0;
      addr_b  <= issue_wr ? (addr_n | ADDR_WIDTH'(1)) : '0;
`endif
    end
  end

`ifdef VERIFY_EN
  // rexp_* hold the expected words of the read being presented; cmp_* hold
  // them one cycle later, aligned with the RAM's read data.
  logic [DATA_WIDTH-1:0] rexp_a, rexp_b, cmp_exp_a, cmp_exp_b;
  logic [ADDR_WIDTH-1:0] cmp_addr_a, cmp_addr_b;
  logic                  cmp_a, cmp_b, mis_a, mis_b;

  assign mis_a = cmp_a && (rdata_a != cmp_exp_a);
  assign mis_b = cmp_b && (rdata_b != cmp_exp_b);

  // Read issue, compare pipeline and the sticky first-mismatch record.
  always_ff @(posedge clk) begin
    if (reset) begin
      re_a       <= 1'b0;
      re_b       <= 1'b0;
      rexp_a     <= '0;
      rexp_b     <= '0;
      cmp_a      <= 1'b0;
      cmp_b      <= 1'b0;
      cmp_exp_a  <= '0;
      cmp_exp_b  <= '0;
      cmp_addr_a <= '0;
      cmp_addr_b <= '0;
      error      <= 1'b0;
      err_addr   <= '0;
    end else begin
      re_a       <= issue_rd;
      re_b       <= issue_rd && b_valid;
      rexp_a     <= even_val;
      rexp_b     <= odd_val;
      cmp_a      <= re_a;
      cmp_b      <= re_b;
      cmp_exp_a  <= rexp_a;
      cmp_exp_b  <= rexp_b;
      cmp_addr_a <= addr_a;
      cmp_addr_b <= addr_b;
      if (state_q == S_IDLE && start) begin
        error    <= 1'b0;
        err_addr <= '0;
      end else if (!error && (mis_a || mis_b)) begin
        // Port A holds the lower address of the pair, so it wins a tie.
        error    <= 1'b1;
        err_addr <= mis_a ? cmp_addr_a : cmp_addr_b;
      end
    end
  end
`else
  logic unused_rdata;
  assign unused_rdata = ^{rdata_a, rdata_b};
  assign re_a     = 1'b0;
  assign re_b     = 1'b0;
  assign error    = 1'b0;
  assign err_addr = '0;
`endif

endmodule

// File: doc/dual_port_mem_writer.md
# dual_port_mem_writer

Sequenced initialisation engine that writes a selectable data pattern into a dual-port RAM, two words per cycle: port A takes even addresses, port B takes odd addresses. It produces exactly the contents the synchronous dual-port ROM generates for the same pattern code, so a RAM can stand in for that ROM after loading. It sits between a control/start source and the write side of the dual-port RAM. When verify is compiled in, it reads the RAM back through both ports and flags the first mismatch.

## Interface
- DATA_WIDTH, 8, word width
- ADDR_WIDTH, 4, address width
- MEM_DEPTH, 1<<ADDR_WIDTH, words to write; may be odd
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  begin a load; sampled only in IDLE
- pattern_sel  in  2  0: zeros; 1: a*a+a; 2: linear (addr); 3: zeros; latched at start
- busy  out  1  high from the cycle after accepted start until the cycle before done
- done  out  1  one-cycle pulse at end of operation
- we_a, we_b  out  1  write enables
- addr_a, addr_b  out  ADDR_WIDTH  write/read addresses
- wdata_a, wdata_b  out  DATA_WIDTH  write data
- re_a, re_b  out  1  read enables (VERIFY_EN only, else tied 0)
- rdata_a, rdata_b  in  DATA_WIDTH  RAM read data, valid 1 cycle after re (VERIFY_EN only)
- error  out  1  sticky mismatch flag, cleared on accepted start (VERIFY_EN only)
- err_addr  out  ADDR_WIDTH  first mismatching address (VERIFY_EN only)

## Operation
- FSM states: IDLE, WRITE, VREAD, VDRAIN, DONE. VREAD and VDRAIN exist only with VERIFY_EN.
- IDLE: start=1 latches pattern_sel, clears error/err_addr and goes to WRITE. start is ignored in every other state.
- WRITE, cycle k (k = 0..ceil(MEM_DEPTH/2)-1):
  - port A writes address 2k; port B writes address 2k+1.
  - On the final cycle with odd MEM_DEPTH, we_b=0.
  - After the last write: go to VREAD if VERIFY_EN, else to DONE.
- Pattern arithmetic (no multiplier), all math mod 2^DATA_WIDTH:
  - quad: f(2k+1) = f(2k) + 2(2k) + 2; f(2k+2) = f(2k) + 4(2k) + 6.
  - linear: value = address truncated to DATA_WIDTH.
- VREAD: same address sequence as WRITE with re_a/re_b in place of we.
  - rdata compared against the regenerated pattern 1 cycle later.
  - VDRAIN covers the last compare, then go to DONE.
- Mismatch: the first mismatch sets error and err_addr. If both ports mismatch in the same cycle, port A's address wins. Later mismatches do not overwrite err_addr.
- DONE: done=1 for one cycle, then IDLE.
- Reset mid-operation: outputs go to their reset values on the next edge and the FSM returns to IDLE. RAM contents already written are left as-is, and no done is produced.

## Timing
- All outputs are registered. Reset value of every output is 0.
- Accepted start at edge N:
  - busy=1 and the first write are presented from cycle N+1.
  - Write k is presented in cycle N+1+k.
- Without VERIFY_EN: done in cycle N+1+W, where W = ceil(MEM_DEPTH/2). Depth 16 gives done at N+9.
- With VERIFY_EN:
  - reads in cycles N+1+W .. N+2W; drain in cycle N+2W+1.
  - done in cycle N+2W+2. Depth 16 gives done at N+18.
  - error is valid in the done cycle.
- we and re are never asserted in the same cycle.

## Configuration
- VERIFY_EN defined:
  - VREAD/VDRAIN states and the compare logic are present.
  - re_a/re_b, error and err_addr are live.
- VERIFY_EN undefined:
  - WRITE goes directly to DONE.
  - re_a, re_b, error and err_addr are driven constant 0.
  - rdata inputs are unused.

## Structure
- Shared package dp_mem_pkg:
  - state enum.
  - pattern codes PAT_ZERO=0, PAT_QUAD=1, PAT_LINEAR=2, shared with the ROM's pattern encoding.
- Sub-module dp_pattern_gen: incremental even/odd pattern pair generator with load and step inputs. It is instantiated once and re-loaded at the start of VREAD.

## Test plan
- Quad pattern, depth 16, DW 8, start at N:
  - wdata_a over the 8 write cycles = 00,06,14,2A,48,6E,9C,D2.
  - addr_a = 0,2,...,14.
  - wdata_b at addr 15 = F0.
  - done at N+9 (N+18 with VERIFY_EN).
- Linear pattern, DW 4, depth 16: addr 13 holds D. Zeros pattern (sel=3): all writes 0.
- Quad pattern, DW 4: addr 5 = E, addr 15 = 0 (wrap).
- VERIFY_EN: bench model forces rdata_b=00 for address 5 and rdata_a=00 for address 8.
  - Required: error=1, err_addr=5 at done.
  - A following clean run clears error.
- Odd depth (MEM_DEPTH=15): last write cycle has we_a=1 at addr 14 and we_b=0.
- start pulsed while busy: ignored, no timing change. reset=1 during the 3rd write cycle: next cycle all outputs 0, no done, and a new start works normally.
